// File: rtl/core_pkg.sv
// Shared fetch-side definitions: reset PC, bubble encoding and the IF/ID record.
package core_pkg;

   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [31:0] NOP_INST         = 32'h0000_0013;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        valid;
   } if_id_t;

   function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
      return pc + 32'd4;
   endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC selection: redirect over stall over increment.
import core_pkg::*;

module pc_reg #(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] pc_o
);

   logic [31:0] pc_q;
   logic [31:0] pc_d;

   // Targets are forced word-aligned; the misalign report, if any, lives upstream.
   always_comb begin
      pc_d = pc_plus4(pc_q);
      if (redirect_i)
         pc_d = redirect_pc_i & ~32'h0000_0003;
      else if (stall_i)
         pc_d = pc_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         pc_q <= RESET_PC;
      else
         pc_q <= pc_d;
   end

   assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, instruction-memory address and IF/ID register.
// Optional FETCH_MISALIGN_TRAP_EN reports redirects to non-word-aligned targets.
import core_pkg::*;

module fetch_stage #(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_pc_i,
   output logic [31:0] imem_addr_o,
   output logic        imem_rst_n_o,
   input  logic [31:0] imem_inst_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_pc4_o,
   output logic [31:0] if_inst_o,
   output logic        if_valid_o,
   output logic        misalign_o,
   output logic [31:0] misalign_addr_o
);

   logic [31:0] pc_q;
   if_id_t      if_id_q;

   pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .stall_i       (stall_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .pc_o          (pc_q)
   );

   // A redirect squashes whatever was fetched on the wrong path, even under stall.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         if_id_q.pc    <= RESET_PC;
         if_id_q.inst  <= NOP_INST;
         if_id_q.valid <= 1'b0;
      end else if (redirect_i || flush_i) begin
         if_id_q.pc    <= pc_q;
         if_id_q.inst  <= NOP_INST;
         if_id_q.valid <= 1'b0;
      end else if (!stall_i) begin
         if_id_q.pc    <= pc_q;
         if_id_q.inst  <= imem_inst_i;
         if_id_q.valid <= 1'b1;
      end
   end

`ifdef FETCH_MISALIGN_TRAP_EN
   logic        misalign_q;
   logic [31:0] misalign_addr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         misalign_q      <= 1'b0;
         misalign_addr_q <= 32'h0;
      end else begin
         misalign_q <= redirect_i && (redirect_pc_i[1:0] != 2'b00);
         if (redirect_i && (redirect_pc_i[1:0] != 2'b00))
            misalign_addr_q <= redirect_pc_i;
      end
   end

   assign misalign_o      = misalign_q;
   assign misalign_addr_o = misalign_addr_q;
`else
   assign misalign_o      = 1'b0;
   assign misalign_addr_o = 32'h0;
`endif

   assign imem_addr_o  = pc_q;
   assign imem_rst_n_o = ~rst_i;
   assign if_pc_o      = if_id_q.pc;
   assign if_pc4_o     = pc_plus4(if_id_q.pc);
   assign if_inst_o    = if_id_q.inst;
   assign if_valid_o   = if_id_q.valid;

endmodule
